// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states and owner codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D wins unless IF is starved.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic d_req,
    input  logic starve_hit,
    input  logic last_grant,
    output logic grant_d
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic unused_starve;
    assign unused_starve = starve_hit;

    // On contention hand the port to whoever did not win last time.
    always_comb begin
        grant_d = d_req && (!if_req || (last_grant == OWN_IF));
    end
`else
    logic unused_last;
    assign unused_last = last_grant;

    always_comb begin
        grant_d = d_req && !(if_req && starve_hit);
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one transaction in flight.
// Build option MEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of fixed priority + starvation guard.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_ready,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wstrb,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy,
    output logic                owner
);

    localparam int STRB_W = DATA_W / 8;

    state_t              state_reg, state_next;
    logic                owner_reg;
    logic                last_grant_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                accept;
    logic                grant_d;
    logic                starve_hit;

    // A request held during reset must not see a ready pulse that is never honoured.
    assign accept = (state_reg == ST_IDLE) && (if_req || d_req) && !rst;

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .d_req      (d_req),
        .starve_hit (starve_hit),
        .last_grant (last_grant_reg),
        .grant_d    (grant_d)
    );

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic [31:0] unused_limit;
    assign unused_limit = 32'(STARVE_LIMIT);
    assign starve_hit   = 1'b0;
`else
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_cnt_reg;

    assign starve_hit = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (accept) begin
            if (!grant_d) begin
                starve_cnt_reg <= '0;
            end else if (if_req && !starve_hit) begin
                starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
            end
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        if_ready   = 1'b0;
        d_ready    = 1'b0;
        mem_req    = 1'b0;
        if_rvalid  = 1'b0;
        d_rvalid   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    state_next = ST_ISSUE;
                    if_ready   = !grant_d;
                    d_ready    = grant_d;
                end
            end
            ST_ISSUE: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
                if_rvalid  = (owner_reg == OWN_IF);
                d_rvalid   = (owner_reg == OWN_D);
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWN_IF;
            last_grant_reg <= OWN_D;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            if_rdata_reg   <= '0;
            d_rdata_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                owner_reg      <= grant_d;
                last_grant_reg <= grant_d;
                if (grant_d) begin
                    we_reg    <= d_we;
                    addr_reg  <= d_addr;
                    wdata_reg <= d_we ? d_wdata : '0;
                    wstrb_reg <= d_we ? d_wstrb : '0;
                end else begin
                    we_reg    <= 1'b0;
                    addr_reg  <= if_addr;
                    wdata_reg <= '0;
                    wstrb_reg <= '0;
                end
            end
            // Response data is captured straight into the owner's hold register.
            if ((state_reg == ST_ISSUE) && mem_ack) begin
                if (owner_reg == OWN_IF) begin
                    if_rdata_reg <= mem_rdata;
                end else begin
                    d_rdata_reg <= we_reg ? '0 : mem_rdata;
                end
            end
        end
    end

    assign busy      = (state_reg != ST_IDLE);
    assign owner     = owner_reg;
    assign mem_we    = we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign mem_wstrb = wstrb_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;

endmodule
